// File: rtl/bcd_pkg.sv
// Shared constants, FSM state type and digit helper for the serial BCD adder.
package bcd_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned BCD_MAX     = 9;
  localparam int unsigned BCD_CORR    = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic bcd_digit_valid(input logic [BCD_DIGIT_W-1:0] d);
    return (d <= BCD_DIGIT_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder with decimal carry correction.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [4:0] z;

  always_comb begin
    z    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
    s    = z[3:0];
    cout = 1'b0;
    // Same rule for non-BCD digits so results remain deterministic.
    if (z > 5'(BCD_MAX)) begin
      s    = z[3:0] + 4'(BCD_CORR);
      cout = 1'b1;
    end
  end

endmodule

// File: rtl/bcd_serial_adder.sv
// Multi-digit packed-BCD adder, one digit per clock, least-significant first.
module bcd_serial_adder
  import bcd_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                invalid
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

  state_t          state;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            carry_q;
  logic [IW-1:0]   idx;
  logic            inv_in;
  logic [3:0]      dig_s;
  logic            dig_c;

  always_comb begin
    inv_in = 1'b0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (!bcd_digit_valid(a[i*BCD_DIGIT_W +: BCD_DIGIT_W]) ||
          !bcd_digit_valid(b[i*BCD_DIGIT_W +: BCD_DIGIT_W]))
        inv_in = 1'b1;
    end
  end

  // Operands shift right each digit so the adder always sees bits [3:0].
  bcd_digit_add u_digit (
    .a    (a_q[3:0]),
    .b    (b_q[3:0]),
    .cin  (carry_q),
    .s    (dig_s),
    .cout (dig_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      sum     <= '0;
      cout    <= 1'b0;
      invalid <= 1'b0;
      idx     <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            sum     <= '0;
            cout    <= 1'b0;
            invalid <= inv_in;
            idx     <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          sum[idx*BCD_DIGIT_W +: BCD_DIGIT_W] <= dig_s;
          carry_q <= dig_c;
          a_q     <= a_q >> BCD_DIGIT_W;
          b_q     <= b_q >> BCD_DIGIT_W;
          if (idx == LAST) begin
            cout  <= dig_c;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Directed self-checking bench for bcd_serial_adder (DIGITS=4 and DIGITS=1).
module tb_bcd_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, invalid;
  logic [15:0] sum;

  logic        start1;
  logic [3:0]  a1, b1;
  logic        cin1;
  logic        busy1, done1, cout1, invalid1;
  logic [3:0]  sum1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bcd_serial_adder #(.DIGITS(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .invalid(invalid)
  );

  bcd_serial_adder #(.DIGITS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .invalid(invalid1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on dut and wait for done; lat = edges after the start edge, -1 on timeout.
  task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vc,
                        output int lat);
    a = va; b = vb; cin = vc; start = 1'b1;
    tick();
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    checks++;
    if ({busy, done, cout, invalid} !== 4'b0000 || sum !== 16'h0000) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b cout=%b invalid=%b sum=%h, required all 0",
               busy, done, cout, invalid, sum);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    int lat;
    a = 16'h1234; b = 16'h5678; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy: busy=%b done=%b, required busy=1 done=0", busy, done);
    end
    tick();
    checks++;
    if (sum !== 16'h0002) begin
      errors++;
      $display("FAIL basic_partial: sum=%h, required 0002", sum);
    end
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      tick();
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL basic_latency: done after edge E+%0d, required E+4", lat);
    end
    checks++;
    if (sum !== 16'h6912 || cout !== 1'b0 || invalid !== 1'b0) begin
      errors++;
      $display("FAIL basic_result: sum=%h cout=%b inv=%b, required 6912 0 0", sum, cout, invalid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || sum !== 16'h6912) begin
      errors++;
      $display("FAIL basic_after: done=%b busy=%b sum=%h, required 0 0 6912", done, busy, sum);
    end
    tick();
  endtask

  task automatic test_carry();
    int lat;
    run_op(16'h9999, 16'h0001, 1'b0, lat);
    checks++;
    if (lat != 4 || sum !== 16'h0000 || cout !== 1'b1) begin
      errors++;
      $display("FAIL carry_ripple: lat=%0d sum=%h cout=%b, required 4 0000 1", lat, sum, cout);
    end
    tick(); tick();
    run_op(16'h0000, 16'h0000, 1'b1, lat);
    checks++;
    if (lat != 4 || sum !== 16'h0001 || cout !== 1'b0) begin
      errors++;
      $display("FAIL carry_in: lat=%0d sum=%h cout=%b, required 4 0001 0", lat, sum, cout);
    end
    tick(); tick();
  endtask

  task automatic test_invalid();
    int lat;
    run_op(16'h00A0, 16'h0005, 1'b0, lat);
    checks++;
    if (lat != 4 || invalid !== 1'b1 || sum !== 16'h0105 || cout !== 1'b0) begin
      errors++;
      $display("FAIL invalid: lat=%0d inv=%b sum=%h cout=%b, required 4 1 0105 0",
               lat, invalid, sum, cout);
    end
    tick(); tick();
  endtask

  task automatic test_back_to_back();
    int first, second, pulses;
    logic [15:0] s_first, s_second;
    logic prev;
    first = -1; second = -1; pulses = 0; prev = 1'b0;
    s_first = '0; s_second = '0;
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'h4321; b = 16'h1234;
    for (int k = 1; k <= 11; k++) begin
      tick();
      if (done && !prev) begin
        pulses++;
        if (first < 0) begin first = k; s_first = sum; end
        else begin second = k; s_second = sum; end
      end
      checks++;
      if (done && prev) begin
        errors++;
        $display("FAIL b2b_width: done high two cycles at edge E+%0d", k);
      end
      prev = done;
    end
    start = 1'b0;
    checks++;
    if (first != 4 || s_first !== 16'h3333) begin
      errors++;
      $display("FAIL b2b_first: done at E+%0d sum=%h, required E+4 3333", first, s_first);
    end
    checks++;
    if (second != 10 || s_second !== 16'h5555 || pulses != 2) begin
      errors++;
      $display("FAIL b2b_second: done at E+%0d sum=%h pulses=%0d, required E+10 5555 2",
               second, s_second, pulses);
    end
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    int lat;
    int seen;
    a = 16'h4444; b = 16'h4444; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || sum !== 16'h0000 || cout !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b sum=%h cout=%b done=%b, required 0 0000 0 0",
               busy, sum, cout, done);
    end
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) seen++;
    end
    checks++;
    if (seen != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done: done pulses=%0d busy=%b, required 0 0", seen, busy);
    end
    run_op(16'h0808, 16'h0303, 1'b1, lat);
    checks++;
    if (lat != 4 || sum !== 16'h1112 || cout !== 1'b0) begin
      errors++;
      $display("FAIL reset_fresh: lat=%0d sum=%h cout=%b, required 4 1112 0", lat, sum, cout);
    end
    tick(); tick();
  endtask

  task automatic test_single_digit();
    int lat;
    a1 = 4'h7; b1 = 4'h5; cin1 = 1'b1; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    checks++;
    if (busy1 !== 1'b1 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL d1_busy: busy=%b done=%b, required 1 0", busy1, done1);
    end
    lat = -1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (done1) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat != 1 || sum1 !== 4'h3 || cout1 !== 1'b1 || invalid1 !== 1'b0) begin
      errors++;
      $display("FAIL d1_result: lat=%0d sum=%h cout=%b inv=%b, required 1 3 1 0",
               lat, sum1, cout1, invalid1);
    end
    tick();
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    test_single_digit();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
